// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths, constants and enums for the
// FP-to-integer datapath and future FP blocks.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;
    localparam int INT_W  = 32;
    localparam int SIG_W  = MANT_W + 1;

    // Exponent at which the significand LSB has weight 2^0.
    localparam logic [EXP_W-1:0] ALIGN_EXP = EXP_W'(BIAS + MANT_W);
    // First exponent whose magnitude no longer fits a signed integer.
    localparam logic [EXP_W-1:0] SAT_EXP   = EXP_W'(BIAS + INT_W - 1);

    localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_e;

    typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} fp_class_e;

    function automatic logic [INT_W-1:0] sat_value(input logic sign);
        return sign ? INT_MIN : INT_MAX;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational single-precision unpack: sign, effective exponent, 24-bit
// significand with hidden bit, and operand class.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [INT_W-1:0] fp,
    output logic             sign,
    output logic [EXP_W-1:0] exp_eff,
    output logic [SIG_W-1:0] sig,
    output fp_class_e        cls
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant;
    logic              exp_zero;
    logic              exp_ones;

    always_comb begin
        sign     = fp[INT_W-1];
        exp_f    = fp[INT_W-2 -: EXP_W];
        mant     = fp[MANT_W-1:0];
        exp_zero = (exp_f == '0);
        exp_ones = (exp_f == '1);
        exp_eff  = exp_zero ? EXP_W'(1) : exp_f;
        sig      = {~exp_zero, mant};
        cls      = NORMAL;
        if (exp_zero)
            cls = (mant == '0) ? ZERO : DENORM;
        else if (exp_ones)
            cls = (mant == '0) ? INF : NAN;
    end

endmodule

// File: rtl/fp_to_int_seq.sv
// Iterative float-to-int32 converter: one alignment bit per cycle, then
// round-to-nearest-even, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for a float
// SHIFT | aligning the significand, one bit per cycle until cnt hits 0
// ROUND | apply RNE, negate, register result and flags
// DONE  | out_valid high, result held until out_ready
module fp_to_int_seq
    import fp_pkg::*;
#(
    parameter int               MAX_RSHIFT = 26,
    parameter logic [INT_W-1:0] NAN_VALUE  = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data,
    output logic             out_invalid,
    output logic             out_inexact
);

    localparam int               CNT_MAX = (MAX_RSHIFT > 7) ? MAX_RSHIFT : 7;
    localparam int               CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [EXP_W-1:0] RCAP    = EXP_W'(MAX_RSHIFT);

    state_e state, state_nxt;

    logic             u_sign;
    logic [EXP_W-1:0] u_exp;
    logic [SIG_W-1:0] u_sig;
    fp_class_e        u_cls;

    logic             accept;
    logic             a_left;
    logic             a_special;
    logic             a_spec_inv;
    logic [INT_W-1:0] a_spec_data;
    logic [EXP_W-1:0] rdist;
    logic [CNT_W-1:0] n_init;

    logic [INT_W-1:0] mag;
    logic             guard;
    logic             sticky;
    logic             sign_r;
    logic             left_r;
    logic             special_r;
    logic             spec_inv_r;
    logic [INT_W-1:0] spec_data_r;
    logic [CNT_W-1:0] cnt;

    logic             incr;
    logic [INT_W-1:0] rounded;
    logic [INT_W-1:0] result;

    fp_unpack u_unpack (
        .fp      (in_data),
        .sign    (u_sign),
        .exp_eff (u_exp),
        .sig     (u_sig),
        .cls     (u_cls)
    );

    assign accept = in_valid & in_ready;

    // Classify at acceptance; specials carry their final value and never shift.
    always_comb begin
        a_left      = (u_exp >= ALIGN_EXP);
        rdist       = ALIGN_EXP - u_exp;
        a_special   = 1'b0;
        a_spec_inv  = 1'b0;
        a_spec_data = '0;
        n_init      = '0;
        if (u_cls == NAN) begin
            a_special   = 1'b1;
            a_spec_inv  = 1'b1;
            a_spec_data = NAN_VALUE;
        end else if (u_cls == INF || u_exp >= SAT_EXP) begin
            a_special = 1'b1;
            if (u_sign && u_exp == SAT_EXP && u_sig == {1'b1, {MANT_W{1'b0}}}) begin
                a_spec_data = INT_MIN;
            end else begin
                a_spec_inv  = 1'b1;
                a_spec_data = sat_value(u_sign);
            end
        end else if (a_left) begin
            n_init = CNT_W'(u_exp - ALIGN_EXP);
        end else if (rdist > RCAP) begin
            n_init = CNT_W'(MAX_RSHIFT);
        end else begin
            n_init = CNT_W'(rdist);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (accept)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == '0)
                    state_nxt = ROUND;
            end
            ROUND: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag         <= '0;
            guard       <= 1'b0;
            sticky      <= 1'b0;
            sign_r      <= 1'b0;
            left_r      <= 1'b0;
            special_r   <= 1'b0;
            spec_inv_r  <= 1'b0;
            spec_data_r <= '0;
            cnt         <= '0;
        end else if (accept) begin
            mag         <= {{(INT_W-SIG_W){1'b0}}, u_sig};
            guard       <= 1'b0;
            sticky      <= 1'b0;
            sign_r      <= u_sign;
            left_r      <= a_left;
            special_r   <= a_special;
            spec_inv_r  <= a_spec_inv;
            spec_data_r <= a_spec_data;
            cnt         <= n_init;
        end else if (state == SHIFT && cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (left_r) begin
                mag <= mag << 1;
            end else begin
                mag    <= mag >> 1;
                guard  <= mag[0];
                sticky <= sticky | guard;
            end
        end
    end

    always_comb begin
        incr    = guard & (sticky | mag[0]);
        rounded = mag + {{(INT_W-1){1'b0}}, incr};
        result  = sign_r ? -rounded : rounded;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else if (state == ROUND) begin
            if (special_r) begin
                out_data    <= spec_data_r;
                out_invalid <= spec_inv_r;
                out_inexact <= 1'b0;
            end else begin
                out_data    <= result;
                out_invalid <= 1'b0;
                out_inexact <= guard | sticky;
            end
        end
    end

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Randomized bench for fp_to_int_seq against an arithmetic reference model,
// with directed cases for ties, range limits, specials, backpressure and reset.
`timescale 1ns/1ps
module tb_fp_to_int_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_inexact;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] d;
        logic        inv;
        logic        inex;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   first = 1'b1;

    fp_to_int_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Value = sig * 2^(E-150), rounded to nearest even by remainder comparison.
    function automatic void model(input logic [31:0] f, output logic [31:0] d,
                                  output logic inv, output logic inex, output int n);
        logic [7:0]  ex;
        logic [22:0] mant;
        logic        sgn;
        int          e, s;
        longint      sig, q, rem, half;
        ex   = f[30:23];
        mant = f[22:0];
        sgn  = f[31];
        e    = (ex == 0) ? 1 : int'(ex);
        sig  = (ex != 0) ? (64'd1 << 23) + longint'(mant) : longint'(mant);
        d = 0; inv = 0; inex = 0; n = 0;
        if (ex == 8'hFF) begin
            inv = 1;
            d   = (mant != 0) ? 32'h8000_0000 : (sgn ? 32'h8000_0000 : 32'h7FFF_FFFF);
        end else if (e >= 158) begin
            if (sgn && e == 158 && mant == 0)
                d = 32'h8000_0000;
            else begin
                inv = 1;
                d   = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            if (e >= 150) begin
                n = e - 150;
                q = sig << n;
            end else begin
                s = 150 - e;
                n = (s > 26) ? 26 : s;
                if (s > 40) s = 40;
                q    = sig >> s;
                rem  = sig - (q << s);
                half = 64'd1 << (s - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
                inex = (rem != 0);
            end
            d = sgn ? 32'(-q) : 32'(q);
        end
    endfunction

    // Checks every cycle the output is meaningful: value, flags, latency, stability.
    always @(negedge clk) begin
        if (rst) begin
            first = 1'b1;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL spurious_valid: got out_valid=1 with data %h, expected no result", out_data);
            end else begin
                cur = exp_q[0];
                if (first) begin
                    chk("latency_edge", 32'(cyc), 32'(cur.due));
                    first = 1'b0;
                end
                chk("out_data", out_data, cur.d);
                chk("out_invalid", 32'(out_invalid), 32'(cur.inv));
                chk("out_inexact", 32'(out_inexact), 32'(cur.inex));
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    first = 1'b1;
                end
            end
        end else if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
            nvec++; nfail++;
            $display("FAIL late_valid: got out_valid=0 at edge %0d, expected 1 by edge %0d", cyc, exp_q[0].due);
            void'(exp_q.pop_front());
            first = 1'b1;
        end
    end

    task automatic wait_ready(output bit ok);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        ok = in_ready;
        if (!ok) begin
            nvec++; nfail++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 100 cycles");
        end
    endtask

    task automatic push_accept(input logic [31:0] f);
        logic [31:0] d;
        logic        inv, inex;
        int          n;
        exp_t        e;
        model(f, d, inv, inex, n);
        in_valid = 1'b1;
        in_data  = f;
        @(posedge clk); #1;
        e.d = d; e.inv = inv; e.inex = inex; e.due = cyc + n + 2;
        exp_q.push_back(e);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send(input logic [31:0] f, input int hold);
        bit ok;
        int t = 0;
        wait_ready(ok);
        if (!ok) return;
        push_accept(f);
        while (exp_q.size() != 0 && t < 200) begin
            if (out_valid && hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1; t++;
        end
        if (exp_q.size() != 0) begin
            nvec++; nfail++;
            $display("FAIL done_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end else begin
            chk("in_ready_after_hs", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic send_lit(input logic [31:0] f, input logic [31:0] ed, input logic ei,
                            input logic ex, input int en, input int hold);
        logic [31:0] d;
        logic        inv, inex;
        int          n;
        model(f, d, inv, inex, n);
        chk("model_data", d, ed);
        chk("model_flags", {30'd0, inv, inex}, {30'd0, ei, ex});
        chk("model_cycles", 32'(n), 32'(en));
        send(f, hold);
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        logic [22:0] m;
        int          e, s;
        f = $urandom;
        m = f[22:0];
        case ($urandom_range(0, 7))
            0: ;
            1, 2, 3: f[30:23] = 8'($urandom_range(100, 160));
            4: f[30:23] = 8'($urandom_range(155, 159));
            5: begin
                e = $urandom_range(128, 149);
                s = 150 - e;
                m = (m & ~((23'd1 << s) - 23'd1)) | (23'd1 << (s - 1));
                f = {f[31], 8'(e), m};
            end
            6: f[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            default: f = {f[31], ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, 23'd0};
        endcase
        return f;
    endfunction

    initial begin
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        send_lit(32'h40490FDB, 32'd3,          1'b0, 1'b1, 22, 0);
        send_lit(32'h3FC00000, 32'd2,          1'b0, 1'b1, 23, 0);
        send_lit(32'h40200000, 32'd2,          1'b0, 1'b1, 22, 0);
        send_lit(32'hC0200000, 32'hFFFF_FFFE,  1'b0, 1'b1, 22, 0);
        send_lit(32'h3F000000, 32'd0,          1'b0, 1'b1, 24, 0);
        send_lit(32'h4EFFFFFF, 32'h7FFF_FF80,  1'b0, 1'b0, 7,  0);
        send_lit(32'hCF000000, 32'h8000_0000,  1'b0, 1'b0, 0,  0);
        send_lit(32'h4F000000, 32'h7FFF_FFFF,  1'b1, 1'b0, 0,  0);
        send_lit(32'h7FC00000, 32'h8000_0000,  1'b1, 1'b0, 0,  0);
        send_lit(32'hFF800000, 32'h8000_0000,  1'b1, 1'b0, 0,  0);
        send_lit(32'h00000000, 32'd0,          1'b0, 1'b0, 26, 0);
        send_lit(32'h00000001, 32'd0,          1'b0, 1'b1, 26, 0);
        send_lit(32'h42F60000, 32'h0000_007B,  1'b0, 1'b0, 17, 5);

        // Abort a conversion three cycles into its shift phase.
        wait_ready(ok);
        if (ok) begin
            push_accept(32'h40490FDB);
            repeat (2) begin @(posedge clk); #1; end
            rst = 1'b1;
            #1;
            chk("abort_out_valid", 32'(out_valid), 32'd0);
            chk("abort_in_ready", 32'(in_ready), 32'd0);
            chk("abort_out_data", out_data, 32'd0);
            exp_q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            chk("abort_idle", 32'(in_ready), 32'd1);
        end
        send_lit(32'h41200000, 32'd10, 1'b0, 1'b0, 20, 0);

        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(rand_float(), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
